// File: rtl/host_cmd_parser_pkg.sv
// host_cmd_parser_pkg: shared types and constants for the host packet parser.
//   HostParseState   - parser FSM state encoding
//   HDR_WORDS/TRL_WORDS - header and trailer sizes in host words
//   CSUM_WIDTH       - payload checksum accumulator width
//   CMD_FIFO_WRITE / AUD_FIFO_WRITE - command codes carried in the header
//   sat_inc16        - saturating 16-bit increment
package host_cmd_parser_pkg;

  typedef enum logic [2:0] {
    S_DEST,
    S_CMD,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CSUM_HI,
    S_CSUM_LO
  } HostParseState;

  localparam int unsigned HDR_WORDS  = 4;
  localparam int unsigned TRL_WORDS  = 2;
  localparam int unsigned CSUM_WIDTH = 32;
  localparam int unsigned LEN_WIDTH  = 24;

  localparam logic [7:0] CMD_FIFO_WRITE = 8'h01;
  localparam logic [7:0] AUD_FIFO_WRITE = 8'h02;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/host_checksum_acc.sv
// host_checksum_acc: 32-bit payload checksum accumulator.
//   clk, reset  - clock, asynchronous active-low reset
//   clear       - zero the running sum (start of a packet)
//   add, word   - add the zero-extended word to the sum, modulo 2^32
//   expected    - received checksum to compare against
//   sum         - current running sum
//   match       - sum equals expected
module host_checksum_acc
  import host_cmd_parser_pkg::*;
#(
  parameter int unsigned word_width = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  add,
  input  logic [word_width-1:0] word,
  input  logic [CSUM_WIDTH-1:0] expected,
  output logic [CSUM_WIDTH-1:0] sum,
  output logic                  match
);

  logic [CSUM_WIDTH-1:0] sum_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_q <= '0;
    end else if (clear) begin
      sum_q <= '0;
    end else if (add) begin
      sum_q <= sum_q + CSUM_WIDTH'(word);
    end
  end

  assign sum   = sum_q;
  assign match = (sum_q == expected);

endmodule

// File: rtl/host_cmd_parser.sv
// host_cmd_parser: splits the host word stream into header, payload and trailer.
//   Header  : dest (word 0 [7:0]), cmd (word 1 [7:0]), 24-bit length (words 2,3)
//   Payload : length words, forwarded to the consumer with zero latency
//   Trailer : 32-bit checksum, high word first
// Ports:
//   clk, reset                  - clock, asynchronous active-low reset
//   in_data/in_valid/in_ready   - host FIFO side
//   hdr_dest/hdr_cmd/hdr_length - latched header fields, hdr_valid pulses when complete
//   out_data/out_valid/out_ready/out_last - payload stream to the consumer
//   pkt_done, pkt_csum_ok, pkt_len_err   - per-packet status pulse
//   err_count                   - saturating count of bad packets
// Build option: define HOST_CMD_TIMEOUT_EN to abort packets that stall for timeout_cycles.
module host_cmd_parser
  import host_cmd_parser_pkg::*;
#(
  parameter int unsigned host_width     = 16,
  parameter int unsigned max_length     = 1024,
  parameter int unsigned timeout_cycles = 4096
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [host_width-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [7:0]            hdr_dest,
  output logic [7:0]            hdr_cmd,
  output logic [LEN_WIDTH-1:0]  hdr_length,
  output logic                  hdr_valid,
  output logic [host_width-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  pkt_done,
  output logic                  pkt_csum_ok,
  output logic                  pkt_len_err,
  output logic [15:0]           err_count
);

  localparam int unsigned TrlBits = TRL_WORDS * host_width;
  localparam logic [LEN_WIDTH-1:0] MaxLen = LEN_WIDTH'(max_length);

  HostParseState         state_q;
  logic [7:0]            hdr_dest_q;
  logic [7:0]            hdr_cmd_q;
  logic [LEN_WIDTH-1:0]  hdr_length_q;
  logic [LEN_WIDTH-1:0]  count_q;
  logic [LEN_WIDTH-1:0]  new_len;
  logic                  hdr_valid_q;
  logic                  pkt_done_q;
  logic                  pkt_csum_ok_q;
  logic                  pkt_len_err_q;
  logic                  drain_q;
  logic [15:0]           err_count_q;
  logic [host_width-1:0] csum_hi_q;
  logic [TrlBits-1:0]    rx_csum;
  logic [CSUM_WIDTH-1:0] csum_sum;
  logic                  csum_match;
  logic                  accept;
  logic                  timeout_hit;

  // Package constants that the datapath does not otherwise need.
  logic unused_pkg;
  assign unused_pkg = ^{CMD_FIFO_WRITE, AUD_FIFO_WRITE, HDR_WORDS, csum_sum};

  assign accept  = in_valid && in_ready;
  assign new_len = {hdr_length_q[LEN_WIDTH-1:16], in_data[15:0]};
  assign rx_csum = {csum_hi_q, in_data};

  host_checksum_acc #(
    .word_width(host_width)
  ) u_csum (
    .clk     (clk),
    .reset   (reset),
    .clear   (accept && (state_q == S_DEST)),
    .add     (accept && (state_q == S_DATA)),
    .word    (in_data),
    .expected(rx_csum),
    .sum     (csum_sum),
    .match   (csum_match)
  );

`ifdef HOST_CMD_TIMEOUT_EN
  localparam int unsigned TimerW = $clog2(timeout_cycles + 1);
  logic [TimerW-1:0] timer_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer_q <= '0;
    end else if ((state_q == S_DEST) || accept || timeout_hit) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_q + 1'b1;
    end
  end

  // Fires on the idle cycle that brings the count up to timeout_cycles.
  assign timeout_hit = (state_q != S_DEST) && !accept &&
                       (timer_q == TimerW'(timeout_cycles - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^timeout_cycles;
  assign timeout_hit    = 1'b0;
`endif

  // Payload passes straight through; a drained (oversized) packet is swallowed.
  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    if ((state_q == S_DATA) && !drain_q) begin
      in_ready  = out_ready;
      out_valid = in_valid;
      out_data  = in_data;
      out_last  = in_valid && (count_q == LEN_WIDTH'(1));
    end
    if (!reset) begin
      in_ready = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_DEST;
      hdr_dest_q    <= '0;
      hdr_cmd_q     <= '0;
      hdr_length_q  <= '0;
      count_q       <= '0;
      hdr_valid_q   <= 1'b0;
      pkt_done_q    <= 1'b0;
      pkt_csum_ok_q <= 1'b0;
      pkt_len_err_q <= 1'b0;
      drain_q       <= 1'b0;
      err_count_q   <= '0;
      csum_hi_q     <= '0;
    end else begin
      hdr_valid_q <= 1'b0;
      pkt_done_q  <= 1'b0;
      if (timeout_hit) begin
        state_q       <= S_DEST;
        pkt_done_q    <= 1'b1;
        pkt_csum_ok_q <= 1'b0;
        pkt_len_err_q <= 1'b0;
        drain_q       <= 1'b0;
        err_count_q   <= sat_inc16(err_count_q);
      end else if (accept) begin
        unique case (state_q)
          S_DEST: begin
            hdr_dest_q <= in_data[7:0];
            state_q    <= S_CMD;
          end
          S_CMD: begin
            hdr_cmd_q <= in_data[7:0];
            state_q   <= S_LEN_HI;
          end
          S_LEN_HI: begin
            hdr_length_q[LEN_WIDTH-1:16] <= in_data[7:0];
            state_q                      <= S_LEN_LO;
          end
          S_LEN_LO: begin
            hdr_length_q <= new_len;
            hdr_valid_q  <= 1'b1;
            count_q      <= new_len;
            drain_q      <= (new_len > MaxLen);
            state_q      <= (new_len == '0) ? S_CSUM_HI : S_DATA;
          end
          S_DATA: begin
            count_q <= count_q - LEN_WIDTH'(1);
            if (count_q == LEN_WIDTH'(1)) begin
              state_q <= S_CSUM_HI;
            end
          end
          S_CSUM_HI: begin
            csum_hi_q <= in_data;
            state_q   <= S_CSUM_LO;
          end
          S_CSUM_LO: begin
            pkt_done_q    <= 1'b1;
            pkt_csum_ok_q <= csum_match;
            pkt_len_err_q <= drain_q;
            if (!csum_match || drain_q) begin
              err_count_q <= sat_inc16(err_count_q);
            end
            drain_q <= 1'b0;
            state_q <= S_DEST;
          end
          default: state_q <= S_DEST;
        endcase
      end
    end
  end

  assign hdr_dest    = hdr_dest_q;
  assign hdr_cmd     = hdr_cmd_q;
  assign hdr_length  = hdr_length_q;
  assign hdr_valid   = hdr_valid_q;
  assign pkt_done    = pkt_done_q;
  assign pkt_csum_ok = pkt_csum_ok_q;
  assign pkt_len_err = pkt_len_err_q;
  assign err_count   = err_count_q;

endmodule
